// File: rtl/integrator_tdm_scheduler_pkg.sv
// integ_tdm_pkg: widths, default coefficients and FSM states for the TDM integrator.
package integ_tdm_pkg;
   localparam int IN_W = 22;
   localparam int COEF_W = 11;
   localparam int PROD_W = 21;
   localparam int OUT_W = 22;
   localparam logic [COEF_W-1:0] B0_DEF = 11'd367;
   localparam logic [COEF_W-1:0] B1_DEF = 11'd1314;
   localparam logic [COEF_W-1:0] B2_DEF = 11'd367;
   typedef enum logic [2:0] {IDLE, M0, M1, M2, WB} state_t;
endpackage

// File: rtl/integrator_tdm_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first request found after the pointer, wrapping.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   localparam int CW = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [CW-1:0]     i_ptr,
   output logic [NUM_CH-1:0] o_grant
);
   // scan farthest to nearest so the nearest request overwrites the rest
   always_comb begin
      o_grant = '0;
      for (int i = NUM_CH; i >= 1; i--)
         if (i_req[(int'(i_ptr) + i) % NUM_CH]) o_grant = NUM_CH'(1) << ((int'(i_ptr) + i) % NUM_CH);
   end
endmodule

// File: rtl/integrator_tdm_scheduler.sv
// integrator_tdm_scheduler: one shared 3-tap integrator MAC time-multiplexed over
// NUM_CH streams with per-channel history, round-robin intake and tagged output.
module integrator_tdm_scheduler
   import integ_tdm_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter logic [COEF_W-1:0] B0 = B0_DEF,
   parameter logic [COEF_W-1:0] B1 = B1_DEF,
   parameter logic [COEF_W-1:0] B2 = B2_DEF,
   localparam int CW = $clog2(NUM_CH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CH-1:0]      ch_valid,
   input  logic [NUM_CH*IN_W-1:0] ch_data,
   output logic [NUM_CH-1:0]      ch_ready,
   input  logic [NUM_CH-1:0]      ch_clear,
   output logic                   out_valid,
   output logic [CW-1:0]          out_ch,
   output logic [OUT_W-1:0]       out_data,
   output logic                   busy
);
   state_t r_state;
   logic [CW-1:0] r_ptr, r_ch, r_out_ch, w_c;
   logic signed [IN_W-1:0] r_x, r_x1s, r_x2s, w_opnd, w_coef_s;
   logic signed [OUT_W-1:0] r_y1s, r_y2s, r_out_data, w_y;
   logic signed [PROD_W-1:0] r_acc, w_prod, w_sum;
   logic signed [IN_W-1:0] r_hx1 [NUM_CH];
   logic signed [IN_W-1:0] r_hx2 [NUM_CH];
   logic signed [OUT_W-1:0] r_hy1 [NUM_CH];
   logic signed [OUT_W-1:0] r_hy2 [NUM_CH];
   logic [NUM_CH-1:0] w_grant;
   logic r_disc, r_out_valid, w_accept;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (.i_req(ch_valid), .i_ptr(r_ptr), .o_grant(w_grant));

   always_comb begin
      w_c = '0;
      for (int i = 0; i < NUM_CH; i++) if (w_grant[i]) w_c = CW'(i);
   end

   assign w_accept  = (r_state == IDLE) && |w_grant;
   assign ch_ready  = (r_state == IDLE) ? w_grant : '0;
   assign busy      = r_state != IDLE;
   assign out_valid = r_out_valid;
   assign out_ch    = r_out_ch;
   assign out_data  = r_out_data;

   // coefficient is unsigned; zero-extend so the signed product keeps its sign from the sample
   assign w_coef_s = {{(IN_W-COEF_W){1'b0}}, (r_state == M0) ? B0 : (r_state == M1) ? B1 : B2};
   assign w_opnd   = (r_state == M0) ? r_x : (r_state == M1) ? r_x1s : r_x2s;
   assign w_prod   = PROD_W'(w_coef_s * w_opnd);
   assign w_sum    = ((r_state == M0) ? '0 : r_acc) + w_prod;
   assign w_y      = {{(OUT_W-PROD_W){r_acc[PROD_W-1]}}, r_acc} + r_y2s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_ptr       <= CW'(NUM_CH - 1);
         r_ch        <= '0;
         r_x         <= '0;
         r_x1s       <= '0;
         r_x2s       <= '0;
         r_y1s       <= '0;
         r_y2s       <= '0;
         r_acc       <= '0;
         r_disc      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_out_data  <= '0;
      end else begin
         r_out_valid <= 1'b0;
         if (w_accept) begin
            r_state <= M0;
            r_ch    <= w_c;
            r_ptr   <= w_c;
            r_x     <= ch_data[w_c*IN_W +: IN_W];
            r_x1s   <= r_hx1[w_c];
            r_x2s   <= r_hx2[w_c];
            r_y1s   <= r_hy1[w_c];
            r_y2s   <= r_hy2[w_c];
            r_disc  <= ch_clear[w_c];
         end else if (r_state == M0 || r_state == M1 || r_state == M2) begin
            r_state <= (r_state == M0) ? M1 : (r_state == M1) ? M2 : WB;
            r_acc   <= w_sum;
            r_disc  <= r_disc | ch_clear[r_ch];
         end else if (r_state == WB) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b1;
            r_out_ch    <= r_ch;
            r_out_data  <= w_y;
         end
      end
   end

   // a clear seen in WB itself lands in the first branch, so it also discards the write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_hx1[k] <= '0;
            r_hx2[k] <= '0;
            r_hy1[k] <= '0;
            r_hy2[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (ch_clear[k]) begin
               r_hx1[k] <= '0;
               r_hx2[k] <= '0;
               r_hy1[k] <= '0;
               r_hy2[k] <= '0;
            end else if (r_state == WB && r_ch == CW'(k) && !r_disc) begin
               r_hx2[k] <= r_x1s;
               r_hx1[k] <= r_x;
               r_hy2[k] <= r_y1s;
               r_hy1[k] <= w_y;
            end
         end
      end
   end
endmodule

// File: tb/tb_integrator_tdm_scheduler.sv
// tb_integrator_tdm_scheduler: directed stimulus with a result scoreboard checked
// by immediate assertions.
module tb_integrator_tdm_scheduler;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] ch_valid = '0;
   logic [87:0] ch_data = '0;
   logic [3:0] ch_ready;
   logic [3:0] ch_clear = '0;
   logic out_valid;
   logic [1:0] out_ch;
   logic signed [21:0] out_data;
   logic busy;
   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   typedef struct {
      int ch;
      logic signed [21:0] y;
      int cyc;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   integrator_tdm_scheduler dut (
      .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
      .ch_ready(ch_ready), .ch_clear(ch_clear), .out_valid(out_valid),
      .out_ch(out_ch), .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         chk("ready_onehot0", 32'($onehot0(ch_ready)), 1);
         if (busy) chk("ready_low_busy", 32'(ch_ready), 0);
         if (out_valid) begin
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               e = sb.pop_front();
               chk("out_ch", 32'(out_ch), e.ch);
               chk("out_data", out_data, e.y);
               chk("latency", cyc, e.cyc + 5);
            end
         end
      end
   end

   task automatic send(input int ch, input logic signed [21:0] x, input logic signed [21:0] y, input bit push);
      int n = 0;
      @(negedge clk);
      ch_valid[ch] = 1'b1;
      ch_data[ch*22 +: 22] = x;
      #1;
      while (!ch_ready[ch] && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("accept_wait", 32'(n < 40), 1);
      if (push) sb.push_back('{ch, y, cyc});
      @(posedge clk);
      #1;
      ch_valid[ch] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_out_ch"}, 32'(out_ch), 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_ready"}, 32'(ch_ready), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      int last, n;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int last, n;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b0;
      // impulse on ch0
      send(0, 256, 93952, 1);
      send(0, 0, 336384, 1);
      chk("busy_after_accept", 32'(busy), 1);
      send(0, 0, 187904, 1);
      send(0, 0, 336384, 1);
      send(0, 0, 187904, 1);
      // step on ch2
      send(2, 256, 93952, 1);
      send(2, 256, 430336, 1);
      send(2, 256, 618240, 1);
      send(2, 256, 954624, 1);
      send(2, 256, 1142528, 1);
      // B1 product wraps at 21 bits on ch1
      send(1, 1024, 375808, 1);
      send(1, 0, -751616, 1);
      drain();
      // clear all history, then clear ch0 while its second sample is in M1
      @(negedge clk);
      ch_clear = 4'hF;
      @(negedge clk);
      ch_clear = 4'h0;
      send(0, 256, 93952, 1);
      send(0, 0, 336384, 1);
      @(posedge clk);
      #1;
      ch_clear[0] = 1'b1;
      @(posedge clk);
      #1;
      ch_clear[0] = 1'b0;
      send(0, 0, 0, 1);
      drain();
      // reset during M2 of an in-flight sample
      send(3, 256, 0, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_idle_outputs("midreset");
      repeat (4) @(negedge clk);
      check_idle_outputs("midreset_hold");
      reset = 1'b0;
      repeat (8) @(negedge clk);
      ch_data = {22'sd256, 22'sd256, 22'sd256, 22'sd256};
      ch_valid = 4'b1010;
      #1;
      chk("post_reset_grant", 32'(ch_ready), 32'b0010);
      sb.push_back('{1, 93952, cyc});
      @(posedge clk);
      #1;
      ch_valid[1] = 1'b0;
      send(3, 256, 93952, 1);
      ch_valid = '0;
      drain();
      // round-robin with all channels requesting from fresh history
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ch_data = {22'sd256, 22'sd256, 22'sd256, 22'sd256};
      ch_valid = 4'hF;
      #1;
      last = 0;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (ch_ready == 4'h0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
         end
         chk("arb_grant", 32'(ch_ready), 32'(1) << (k % 4));
         if (k > 0) chk("arb_spacing", cyc - last, 5);
         last = cyc;
         sb.push_back('{k % 4, (k == 4) ? 22'sd430336 : 22'sd93952, cyc});
         @(posedge clk);
         #1;
      end
      ch_valid = '0;
      drain();
      repeat (10) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/integrator_tdm_scheduler.md
Name: integrator_tdm_scheduler

Overview:
- Time-multiplexes one shared 3-tap integrator datapath across NUM_CH independent sample streams. Each stream has its own integrator state.
- Per-channel recurrence: y[n] = B0·x[n] + B1·x[n-1] + B2·x[n-2] + y[n-2].
- One multiplier is sequenced over three cycles per sample. Requesters are served round-robin via valid/ready. Results leave on a single tagged output stream.
- Sits between the sample front-end and downstream filtering.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- B0, 11'd367, tap-0 coefficient, ufix11_En10
- B1, 11'd1314, tap-1 coefficient, ufix11_En10
- B2, 11'd367, tap-2 coefficient, ufix11_En10

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- ch_valid  in  NUM_CH  per-channel sample valid
- ch_data  in  NUM_CH*22  packed samples, sfix22_En10; channel i at [22i+21:22i]
- ch_ready  out  NUM_CH  one-hot grant; sample accepted when valid&ready
- ch_clear  in  NUM_CH  per-channel history clear
- out_valid  out  1  result strobe, one cycle
- out_ch  out  $clog2(NUM_CH)  channel of result
- out_data  out  22  result, sfix22_En20
- busy  out  1  high when FSM is not IDLE

Behaviour:
- Reset:
  - FSM=IDLE; all history (x1, x2, y1, y2 per channel) = 0; working registers = 0.
  - out_valid=0, out_ch=0, out_data=0, ch_ready=0, busy=0.
  - RR pointer = NUM_CH-1, so channel 0 has first priority.
  - Reset asserted mid-operation aborts the sample in flight; no output is emitted.
- FSM states: IDLE -> M0 -> M1 -> M2 -> WB -> IDLE, one cycle each, unconditional once a sample is accepted.
- IDLE:
  - ch_ready = one-hot of the first asserted ch_valid searching from pointer+1 (mod NUM_CH); all zero if no request.
  - ready may depend on valid; requesters must not make valid depend on ready.
  - On accept: latch channel c and x; snapshot x1[c], x2[c], y1[c], y2[c]; pointer <= c; go to M0.
- ch_ready = 0 in all other states.
- Arithmetic (shared multiplier, operand {1'b0,coef} 12-bit signed × 22-bit signed):
  - Each product truncated to bits [20:0] (sfix21_En20, wrap).
  - M0: acc = P(B0,x). M1: acc = acc + P(B1,x1), 21-bit wrap. M2: acc = acc + P(B2,x2), 21-bit wrap.
  - WB: y = sext22(acc) + y2, 22-bit wrap, no saturation anywhere.
- WB history write, unless discarded: x2<=x1, x1<=x, y2<=y1, y1<=y.
- Output:
  - Registered. out_valid=1 in the cycle after WB, with out_ch=c and out_data=y; out_ch/out_data hold until the next result.
  - Latency: accept at edge t -> out_valid high during cycle t+5.
  - Throughput: one sample per 5 cycles; a new accept may coincide with out_valid.
- Clear:
  - ch_clear[k]=1 zeroes all history of channel k at the next edge.
  - If k is the channel in flight and ch_clear[k] is seen in any cycle from accept through WB, the WB history write is discarded (history stays 0). The result is still emitted, computed from the snapshot.
  - Clear of a channel not in flight has no effect on the operation in progress.
  - Clear is independent of valid; clear and accept on the same channel in the same cycle: the snapshot takes pre-clear values and the WB write is discarded.

Decomposition:
- Package integ_tdm_pkg holds:
  - width constants IN_W=22, COEF_W=11, PROD_W=21, OUT_W=22
  - default coefficient constants
  - FSM state enum {IDLE, M0, M1, M2, WB}
- One sub-module: rr_arbiter (NUM_CH request vector, pointer in, one-hot grant out, purely combinational).
- History banks, MAC and FSM live in the top level.

Test Plan:
- Impulse, ch0: x=256 then 0,0,0,0 -> out_data = 93952, 336384, 187904, 336384, 187904; out_ch=0 each time.
- Step, ch2: x=256 constant -> out_data = 93952, 430336, 618240, 954624, 1142528.
- Wrap, ch1: x=1024 then 0 -> out_data = 375808, then -751616 (B1 product wraps at 21 bits).
- Arbitration: all four ch_valid held high -> accept order 0,1,2,3,0; accepts 5 cycles apart; first out_valid exactly 5 cycles after first accept; ch_ready one-hot and low outside IDLE.
- Clear: ch0 impulse x=256; assert ch_clear[0] during M1 of the second sample -> that result still equals 336384, and the following x=0 sample yields 0.
- Reset in M2 -> no out_valid; all outputs 0; the next accept goes to the lowest requesting channel; history is zero.
